// File: rtl/cla_pkg.sv
// cla_pkg: shared slice width and result type for the 32-bit carry-lookahead slices.
package cla_pkg;
    localparam int CLA_SLICE_W = 32;
    typedef struct packed {
        logic [CLA_SLICE_W-1:0] sum;
        logic                   co;
    } cla_res_t;
endpackage

// File: rtl/cla_32bits.sv
// cla_32bits: combinational 32-bit carry-lookahead adder slice.
// 4-bit lookahead groups feed a group-level carry chain.
module cla_32bits
    import cla_pkg::*;
(
    input  logic [CLA_SLICE_W-1:0] a,
    input  logic [CLA_SLICE_W-1:0] b,
    input  logic                   ci,
    output cla_res_t               res
);
    logic [CLA_SLICE_W-1:0] g, p, c;
    logic [7:0] gg, pg;
    logic [8:0] cg;
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        gg = '0;
        pg = '0;
        cg = '0;
        cg[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
            cg[k+1] = gg[k] | (pg[k] & cg[k]);
        end
    end
    assign res.sum = p ^ c;
    assign res.co  = cg[8];
endmodule

// File: rtl/cla_add_pipe_64.sv
// cla_add_pipe_64: 2-stage valid/ready 64-bit adder; low half in stage 1, high half in stage 2.
// Define CLA_ADD_PIPE_OVF_EN to add the signed-overflow output ovf.
module cla_add_pipe_64
    import cla_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef CLA_ADD_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);
    localparam int HALF = WIDTH / 2;

    if (WIDTH != 2 * CLA_SLICE_W) begin : g_bad_width
        $error("cla_add_pipe_64: WIDTH must equal 2*CLA_SLICE_W");
    end

    logic            v1, v2, rdy1, rdy2, c_mid;
    logic [HALF-1:0] lo_sum, a_hi, b_hi;
    cla_res_t        lo_res, hi_res;

    cla_32bits u_cla_lo (.a(a[HALF-1:0]), .b(b[HALF-1:0]), .ci(ci), .res(lo_res));
    cla_32bits u_cla_hi (.a(a_hi), .b(b_hi), .ci(c_mid), .res(hi_res));

    assign rdy2      = !v2 || out_ready;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            lo_sum <= '0;
            c_mid  <= 1'b0;
            a_hi   <= '0;
            b_hi   <= '0;
            v2     <= 1'b0;
            s      <= '0;
            co     <= 1'b0;
        end else begin
            if (rdy1) v1 <= in_valid;
            if (rdy1 && in_valid) begin
                lo_sum <= lo_res.sum;
                c_mid  <= lo_res.co;
                a_hi   <= a[WIDTH-1:HALF];
                b_hi   <= b[WIDTH-1:HALF];
            end
            if (rdy2) v2 <= v1;
            if (rdy2 && v1) begin
                s  <= {hi_res.sum, lo_sum};
                co <= hi_res.co;
            end
        end
    end

`ifdef CLA_ADD_PIPE_OVF_EN
    // Same-sign operands whose sum flips sign overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (rdy2 && v1) ovf <= (a_hi[HALF-1] ~^ b_hi[HALF-1]) & (hi_res.sum[HALF-1] ^ a_hi[HALF-1]);
    end
`endif
endmodule
